// File: rtl/fir_coef_loader.sv
// Coefficient frame receiver for the symmetric FIR: syncs on 0xA5 0x5A, buffers NUM_TAPS 16-bit coefficients and replays them.
// Optional trailing mod-256 checksum byte is enabled by defining FIR_COEF_LOADER_CHECKSUM_EN.
module fir_coef_loader #(
    parameter int NUM_TAPS    = 50,
    parameter int CNT_W       = 6,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             out_ing_valid,
    output logic [CNT_W-1:0] out_cnt,
    output logic [15:0]      fir_data,
    output logic             load_done,
    output logic             frame_err,
    output logic             busy
);
    localparam int BYTES = 2 * NUM_TAPS;
    localparam int BCW   = $clog2(BYTES);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SYNC1 = 8'hA5;
    localparam logic [7:0] SYNC2 = 8'h5A;

    typedef enum logic [2:0] {IDLE, HDR2, DATA, CSUM, STREAM} state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]         sum_q, sum_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               valid_d, done_d, err_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [15:0]        data_d;
    logic [7:0]         msb_q;
    logic signed [15:0] coef [NUM_TAPS];
    logic [CNT_W-1:0]   wr_idx;
    logic               in_frame;
    logic               last_byte;

    assign wr_idx    = CNT_W'(byte_cnt_q >> 1);
    assign in_frame  = (state_q == HDR2) || (state_q == DATA) || (state_q == CSUM);
    assign last_byte = (byte_cnt_q == BCW'(BYTES - 1));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sum_d      = sum_q;
        tmo_d      = '0;
        valid_d    = 1'b0;
        cnt_d      = '0;
        data_d     = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (in_frame && !rx_valid)
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC1)
                    state_d = HDR2;
            end
            HDR2: begin
                if (rx_valid) begin
                    if (rx_data == SYNC2) begin
                        state_d    = DATA;
                        byte_cnt_d = '0;
                        sum_d      = '0;
                    end else if (rx_data != SYNC1) begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    sum_d      = sum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (last_byte) begin
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        // With a single tap the word completing now is not yet in the buffer.
                        state_d = STREAM;
                        valid_d = 1'b1;
                        data_d  = (NUM_TAPS == 1) ? {msb_q, rx_data} : coef[0];
`endif
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = STREAM;
                        valid_d = 1'b1;
                        data_d  = coef[0];
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_cnt == CNT_W'(NUM_TAPS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    cnt_d   = out_cnt + 1'b1;
                    data_d  = coef[cnt_d];
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            sum_q         <= '0;
            tmo_q         <= '0;
            out_ing_valid <= 1'b0;
            out_cnt       <= '0;
            fir_data      <= '0;
            load_done     <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            sum_q         <= sum_d;
            tmo_q         <= tmo_d;
            out_ing_valid <= valid_d;
            out_cnt       <= cnt_d;
            fir_data      <= data_d;
            load_done     <= done_d;
            frame_err     <= err_d;
        end
    end

    // Coefficient buffer is pure data: written in place, never reset.
    always_ff @(posedge clk) begin
        if (state_q == DATA && rx_valid) begin
            if (!byte_cnt_q[0])
                msb_q <= rx_data;
            else
                coef[wr_idx] <= {msb_q, rx_data};
        end
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: good frames, checksum error, resync, timeout, stream injection and mid-stream reset.
module tb_fir_coef_loader;
    localparam int NUM_TAPS    = 50;
    localparam int CNT_W       = 6;
    localparam int TIMEOUT_CYC = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             out_ing_valid;
    logic [CNT_W-1:0] out_cnt;
    logic [15:0]      fir_data;
    logic             load_done;
    logic             frame_err;
    logic             busy;

    int n_assert = 0;
    int n_fail   = 0;

    fir_coef_loader #(
        .NUM_TAPS    (NUM_TAPS),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .out_ing_valid (out_ing_valid),
        .out_cnt       (out_cnt),
        .fir_data      (fir_data),
        .load_done     (load_done),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pattern 0: k*100-2500; pattern 1: near-full-scale alternating signs.
    function automatic logic [15:0] coef_of(input int pat, input int k);
        if (pat == 0)
            return 16'(k * 100 - 2500);
        else if (k % 2 == 0)
            return 16'(32767 - k);
        else
            return 16'(-32768 + k);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_payload(input int pat, input int nbytes, output logic [7:0] sum);
        logic [15:0] w;
        sum = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            w = coef_of(pat, i / 2);
            if (i % 2 == 0) begin
                send_byte(w[15:8]);
                sum = sum + w[15:8];
            end else begin
                send_byte(w[7:0]);
                sum = sum + w[7:0];
            end
        end
    endtask

    // Payload plus (when built in) the checksum byte offset by delta.
    task automatic send_body(input int pat, input logic [7:0] delta);
        logic [7:0] sum;
        send_payload(pat, 2 * NUM_TAPS, sum);
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
        send_byte(sum + delta);
`endif
    endtask

    task automatic send_frame(input int pat);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_body(pat, 8'h00);
    endtask

    task automatic expect_stream(input string tag, input int pat, input bit inject);
        for (int k = 0; k < NUM_TAPS; k++) begin
            chk($sformatf("%s_valid[%0d]", tag, k), out_ing_valid, 1);
            chk($sformatf("%s_cnt[%0d]", tag, k), out_cnt, k);
            chk($sformatf("%s_data[%0d]", tag, k), fir_data, coef_of(pat, k));
            if (k == 0)
                chk($sformatf("%s_busy", tag), busy, 1);
            if (inject && (k == 10 || k == 11)) begin
                rx_data  = (k == 10) ? 8'hA5 : 8'h5A;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            tick();
        end
        rx_valid = 1'b0;
        chk($sformatf("%s_end_valid", tag), out_ing_valid, 0);
        chk($sformatf("%s_end_cnt", tag), out_cnt, 0);
        chk($sformatf("%s_end_data", tag), fir_data, 0);
        chk($sformatf("%s_done", tag), load_done, 1);
        chk($sformatf("%s_end_busy", tag), busy, 0);
        tick();
        chk($sformatf("%s_done_pulse", tag), load_done, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        int  waited;
        bit  seen_done;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_ing_valid, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_data", fir_data, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        send_frame(0);
        expect_stream("good0", 0, 1'b0);

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_body(0, 8'h01);
        chk("csum_err", frame_err, 1);
        chk("csum_valid", out_ing_valid, 0);
        chk("csum_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("csum_after_err[%0d]", i), frame_err, 0);
            chk($sformatf("csum_after_valid[%0d]", i), out_ing_valid, 0);
        end
`endif
        send_frame(1);
        expect_stream("good1", 1, 1'b0);

        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_body(0, 8'h00);
        expect_stream("resync", 0, 1'b0);

        send_byte(8'hA5);
        chk("hdr2_busy", busy, 1);
        send_byte(8'h11);
        chk("badhdr_busy", busy, 0);
        chk("badhdr_err", frame_err, 0);
        send_byte(8'h5A);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i));
            chk($sformatf("badhdr_valid[%0d]", i), out_ing_valid, 0);
            chk($sformatf("badhdr_err[%0d]", i), frame_err, 0);
        end
        chk("badhdr_idle", busy, 0);

        begin
            logic [7:0] partial_sum;
            send_byte(8'hA5);
            send_byte(8'h5A);
            send_payload(1, 40, partial_sum);
        end
        chk("tmo_busy_before", busy, 1);
        chk("tmo_err_before", frame_err, 0);
        waited = 0;
        while (frame_err !== 1'b1 && waited < TIMEOUT_CYC + 100) begin
            tick();
            waited++;
        end
        chk("tmo_cycles", waited, TIMEOUT_CYC);
        chk("tmo_err", frame_err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_valid", out_ing_valid, 0);
        tick();
        chk("tmo_err_pulse", frame_err, 0);
        send_frame(0);
        expect_stream("after_tmo", 0, 1'b0);

        send_frame(1);
        expect_stream("inject", 1, 1'b1);
        send_frame(0);
        expect_stream("after_inject", 0, 1'b0);

        send_frame(1);
        for (int k = 0; k < 20; k++)
            tick();
        chk("midrst_cnt_before", out_cnt, 20);
        chk("midrst_valid_before", out_ing_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_ing_valid, 0);
        chk("midrst_cnt", out_cnt, 0);
        chk("midrst_data", fir_data, 0);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (load_done === 1'b1 || out_ing_valid === 1'b1)
                seen_done = 1'b1;
        end
        chk("midrst_no_done", seen_done, 0);
        send_frame(0);
        expect_stream("after_rst", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
